// File: rtl/corr_branch_pred_param.sv
// corr_branch_pred_param: parametrised (m,n) correlating branch predictor.
// An m-bit global history register plus PC index bits select an n-bit
// saturating counter in a clocked branch history table (BHT). Lookups are
// registered; updates arrive from EX carrying the original lookup index.
// The table has no reset; an init sequencer fills it after reset/clear.
// Optional feature macro: CBP_GSHARE_INDEX_EN (gshare XOR index hashing).
module corr_branch_pred_param #(
  parameter int GHR_BITS = 1,
  parameter int IDX_BITS = 3,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 3,
  parameter int STAT_W   = 32,
  localparam int TBL_BITS = GHR_BITS + IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tbl_clear,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [TBL_BITS-1:0] pred_index,
  input  logic                upd_valid,
  input  logic [TBL_BITS-1:0] upd_index,
  input  logic                upd_taken,
  input  logic                upd_pred,
  output logic                init_busy,
  output logic [STAT_W-1:0]   stat_branches,
  output logic [STAT_W-1:0]   stat_mispred
);

  localparam int                  DEPTH    = 1 << TBL_BITS;
  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(INIT_CTR);
  localparam logic [TBL_BITS-1:0] LAST_PTR = TBL_BITS'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [TBL_BITS-1:0]   init_ptr, init_ptr_nxt;
  logic [GHR_BITS-1:0]   ghr;
  logic [TBL_BITS-1:0]   idx;
  logic [CTR_BITS-1:0]   bht [DEPTH];
  logic [CTR_BITS-1:0]   upd_ctr, upd_nxt;

  assign init_busy = (state == S_INIT);

  // Lookup index from the current (pre-edge) history.
`ifdef CBP_GSHARE_INDEX_EN
  assign idx = pred_pc[TBL_BITS+1:2] ^ {ghr, {IDX_BITS{1'b0}}};
  logic unused_pc;
  assign unused_pc = ^{pred_pc[31:TBL_BITS+2], pred_pc[1:0]};
`else
  assign idx = {ghr, pred_pc[IDX_BITS+1:2]};
  logic unused_pc;
  assign unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};
`endif

  // Init sequencer state register; reset restarts the fill from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  // Next-state: walk every entry once, then run; clear always restarts at 0.
  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    if (tbl_clear) begin
      state_nxt    = S_INIT;
      init_ptr_nxt = '0;
    end else begin
      case (state)
        S_INIT: begin
          init_ptr_nxt = init_ptr + TBL_BITS'(1);
          if (init_ptr == LAST_PTR) state_nxt = S_RUN;
        end
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // Saturating counter step for the resolved branch.
  assign upd_ctr = bht[upd_index];
  always_comb begin
    upd_nxt = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != '1) upd_nxt = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_nxt = upd_ctr - CTR_BITS'(1);
    end
  end

  // Table write port: init fill has priority; updates during init are dropped.
  always_ff @(posedge clk) begin
    if (state == S_INIT)  bht[init_ptr]  <= INIT_VAL;
    else if (upd_valid)   bht[upd_index] <= upd_nxt;
  end

  // Registered prediction; reads see the pre-update counter (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        pred_taken <= (state == S_INIT) ? INIT_VAL[CTR_BITS-1]
                                        : bht[idx][CTR_BITS-1];
        pred_index <= idx;
      end
    end
  end

  // Global history shifts in the resolved outcome, in any state.
  generate
    if (GHR_BITS == 1) begin : g_ghr1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ghr <= '0;
        else if (upd_valid) ghr <= upd_taken;
      end
    end else begin : g_ghrn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ghr <= '0;
        else if (upd_valid) ghr <= {ghr[GHR_BITS-2:0], upd_taken};
      end
    end
  endgenerate

  // Saturating resolve statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
      if ((upd_pred != upd_taken) && (stat_mispred != '1))
        stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_corr_branch_pred_param.sv
// Directed bench for corr_branch_pred_param (default parameters) plus a
// STAT_W=4 instance sharing the inputs for statistics saturation.
module tb_corr_branch_pred_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_clear, pred_req, upd_valid, upd_taken, upd_pred;
  logic [31:0] pred_pc;
  logic [3:0]  upd_index;
  logic        pred_valid, pred_taken, init_busy;
  logic [3:0]  pred_index;
  logic [31:0] stat_branches, stat_mispred;
  logic        pv4, pt4, ib4;
  logic [3:0]  pi4, sb4, sm4;

  int n_chk = 0;
  int n_fail = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  corr_branch_pred_param dut (
    .clk(clk), .rst_n(rst_n), .tbl_clear(tbl_clear), .pred_req(pred_req),
    .pred_pc(pred_pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_pred(upd_pred), .init_busy(init_busy),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred));

  corr_branch_pred_param #(.STAT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tbl_clear(tbl_clear), .pred_req(pred_req),
    .pred_pc(pred_pc), .pred_valid(pv4), .pred_taken(pt4),
    .pred_index(pi4), .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_taken(upd_taken), .upd_pred(upd_pred), .init_busy(ib4),
    .stat_branches(sb4), .stat_mispred(sm4));

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        uv;
    logic [3:0]  ui;
    logic        ut;
    logic        up;
    logic        ev;
    logic        et;
    logic [3:0]  ei;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

`ifdef CBP_GSHARE_INDEX_EN
  localparam logic [3:0] PC30_IDX = 4'h4;
`else
  localparam logic [3:0] PC30_IDX = 4'hC;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1ns after the edge.
  task automatic tick(input logic rq, input logic [31:0] pc, input logic uv,
                      input logic [3:0] ui, input logic ut, input logic up,
                      input logic clr);
    pred_req = rq; pred_pc = pc; upd_valid = uv; upd_index = ui;
    upd_taken = ut; upd_pred = up; tbl_clear = clr;
    @(posedge clk); #1;
    if (uv) begin
      exp_br++;
      if (up != ut) exp_mp++;
    end
    pred_req = 0; upd_valid = 0; tbl_clear = 0;
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, " branches"}, stat_branches, exp_br);
    chk({nm, " mispred"}, stat_mispred, exp_mp);
    chk({nm, " branches4"}, {28'd0, sb4}, (exp_br > 15) ? 15 : exp_br);
    chk({nm, " mispred4"}, {28'd0, sm4}, (exp_mp > 15) ? 15 : exp_mp);
  endtask

  // Count cycles until init_busy falls (bounded).
  task automatic wait_init(input string nm);
    int n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      tick(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    chk(nm, n, 16);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " valid"}, pred_valid, 0);
    chk({nm, " taken"}, pred_taken, 0);
    chk({nm, " index"}, pred_index, 0);
    chk({nm, " busy"}, init_busy, 1);
    chk({nm, " branches"}, stat_branches, 0);
    chk({nm, " mispred"}, stat_mispred, 0);
    chk({nm, " branches4"}, sb4, 0);
  endtask

  initial begin
    //           req pc      uv ui    ut up   ev et ei
    tbl[0]  = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 1, 4'h4};
    tbl[1]  = '{0, 32'h00, 1, 4'h4, 0, 1,  0, 1, 4'h4};
    tbl[2]  = '{0, 32'h00, 1, 4'h4, 0, 1,  0, 1, 4'h4};
    tbl[3]  = '{0, 32'h00, 1, 4'h4, 0, 0,  0, 1, 4'h4};
    tbl[4]  = '{0, 32'h00, 1, 4'h4, 0, 0,  0, 1, 4'h4};
    tbl[5]  = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 0, 4'h4};
    tbl[6]  = '{0, 32'h00, 1, 4'h4, 1, 0,  0, 0, 4'h4};
    tbl[7]  = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 1, 4'hC};
    tbl[8]  = '{0, 32'h00, 1, 4'h7, 0, 1,  0, 1, 4'hC};
    tbl[9]  = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 0, 4'h4};
    tbl[10] = '{0, 32'h00, 1, 4'h4, 1, 1,  0, 0, 4'h4};
    tbl[11] = '{0, 32'h00, 1, 4'h7, 0, 1,  0, 0, 4'h4};
    tbl[12] = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 1, 4'h4};
    tbl[13] = '{1, 32'h10, 1, 4'h4, 0, 1,  1, 1, 4'h4};
    tbl[14] = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 0, 4'h4};
    tbl[15] = '{1, 32'h14, 1, 4'h4, 1, 0,  1, 1, 4'h5};
    tbl[16] = '{1, 32'h14, 0, 4'h0, 0, 0,  1, 1, 4'hD};
    tbl[17] = '{0, 32'h00, 1, 4'h4, 1, 1,  0, 1, 4'hD};
    tbl[18] = '{0, 32'h00, 1, 4'h4, 1, 1,  0, 1, 4'hD};
    tbl[19] = '{0, 32'h00, 1, 4'hE, 0, 1,  0, 1, 4'hD};
    tbl[20] = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 1, 4'h4};
    tbl[21] = '{0, 32'h00, 1, 4'h4, 0, 0,  0, 1, 4'h4};
    tbl[22] = '{1, 32'h10, 0, 4'h0, 0, 0,  1, 1, 4'h4};
    tbl[23] = '{0, 32'h00, 1, 4'h7, 0, 0,  0, 1, 4'h4};
    tbl[24] = '{1, 32'h1C, 0, 4'h0, 0, 0,  1, 0, 4'h7};
    tbl[25] = '{0, 32'h00, 1, 4'h7, 1, 1,  0, 0, 4'h7};
    tbl[26] = '{1, 32'h30, 0, 4'h0, 0, 0,  1, 1, PC30_IDX};

    rst_n = 0; tbl_clear = 0; pred_req = 0; pred_pc = 0;
    upd_valid = 0; upd_index = 0; upd_taken = 0; upd_pred = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1;
    wait_init("init length after reset");

    for (int i = 0; i < NV; i++) begin
      tick(tbl[i].req, tbl[i].pc, tbl[i].uv, tbl[i].ui, tbl[i].ut, tbl[i].up, 0);
      chk($sformatf("vec%0d valid", i), pred_valid, tbl[i].ev);
      chk($sformatf("vec%0d taken", i), pred_taken, tbl[i].et);
      chk($sformatf("vec%0d index", i), pred_index, tbl[i].ei);
      chk_stats($sformatf("vec%0d", i));
    end

    // Drive entry 4 to 0 (2 -> 1 -> 0), history back to 0.
    tick(0, 0, 1, 4'h4, 0, 0, 0);
    tick(0, 0, 1, 4'h4, 0, 0, 0);
    tick(1, 32'h10, 0, 0, 0, 0, 0);
    chk("pre-clear taken", pred_taken, 0);

    // Clear in RUN: lookup during init, dropped updates, exact init length.
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("clear busy", init_busy, 1);
    begin
      int n = 0;
      while (init_busy === 1'b1 && n < 100) begin
        if (n == 0)                tick(1, 32'h10, 0, 0, 0, 0, 0);
        else if (n == 8 || n == 9) tick(0, 0, 1, 4'h4, 0, 0, 0);
        else                       tick(0, 0, 0, 0, 0, 0, 0);
        if (n == 0) begin
          chk("init lookup valid", pred_valid, 1);
          chk("init lookup taken", pred_taken, 1);
        end
        n++;
      end
      chk("init length after clear", n, 16);
    end
    tick(1, 32'h10, 0, 0, 0, 0, 0);
    chk("post-clear valid", pred_valid, 1);
    chk("post-clear taken", pred_taken, 1);
    chk("post-clear index", pred_index, 4);
    chk_stats("post-clear");

    // Mispredicts until the narrow counters pin at 0xF.
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 4'h0, 0, 1, 0);
    chk_stats("saturate");
    chk("mispred4 pinned", sm4, 4'hF);

    // Async reset mid-RUN, then mid-INIT.
    #2 rst_n = 0;
    #1;
    exp_br = 0; exp_mp = 0;
    chk_reset_vals("run reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (5) tick(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk_reset_vals("init reset");
    @(posedge clk); #1 rst_n = 1;
    wait_init("init length after mid-init reset");

    // Clear while already initialising restarts the count.
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (5) tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    wait_init("init length after clear in init");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
